writeback_regfile: RTL
======================

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath and register width.
REQ-002 The block SHALL have parameter NREG, default 32: architectural register count (x0..x31).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 RegWriteW  input  1  write-enable from the MEM/WB pipeline register.
REQ-006 ResultSrcW  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-007 ALUResultW  input  XLEN  ALU result; bits [1:0] give the load byte offset.
REQ-008 ReadDataW  input  XLEN  raw aligned data-memory word.
REQ-009 PCPlus4W  input  XLEN  link value for JAL/JALR.
REQ-010 RdW  input  5  destination register index.
REQ-011 LoadTypeW  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 A1, A2  input  5 each  decode-stage read addresses (rs1, rs2).
REQ-013 RD1, RD2  output  XLEN each  read data for A1, A2.
REQ-014 ResultW  output  XLEN  final writeback value, for EX-stage forwarding.

Function
REQ-015 The load path SHALL select a byte or halfword from ReadDataW by ALUResultW[1:0]: byte lane = offset; halfword lane = offset[1]; LW ignores offset.
REQ-016 The load path SHALL sign-extend for LB/LH, zero-extend for LBU/LHU, and pass LW unchanged; undefined LoadTypeW codes SHALL behave as LW.
REQ-017 ResultW SHALL be combinational from the W-stage inputs per REQ-006, with a latency of zero cycles.
REQ-018 On a rising clk with reset high, RegWriteW=1 and RdW!=0, register[RdW] SHALL take ResultW.
REQ-019 Register x0 SHALL read as 0 at all times, and writes to x0 SHALL be discarded.
REQ-020 Reads SHALL be combinational: RD1 = reg[A1] and RD2 = reg[A2].
REQ-021 Write-through bypass: when RegWriteW=1, RdW!=0, reset high, and RdW==A1 (or A2), RD1 (or RD2) SHALL equal the current ResultW in the same cycle.
REQ-022 When A1==A2, both ports SHALL return identical data, including the bypass case.
REQ-023 RegWriteW=0 SHALL leave all registers unchanged, whatever the values of RdW and ResultSrcW.

Reset
REQ-024 On a rising clk with reset=0, registers x1..x31 SHALL clear to 0 and no write SHALL occur, even if RegWriteW=1.
REQ-025 While reset=0, the bypass SHALL be disabled; RD1/RD2 SHALL show register contents.
REQ-026 ResultW SHALL remain purely combinational and is not affected by reset.
REQ-027 If reset is asserted mid-program, it SHALL override any pending write in that cycle, and the first write after release SHALL occur on the first rising edge with reset=1.

Structure
REQ-028 Package riscv_pkg SHALL hold the result_src_t enum (ALU, LOAD, PC4), the load funct3 constants, and XLEN_DEFAULT.
REQ-029 Load alignment and extension SHALL be a separate combinational sub-module, load_extend (inputs: word, offset, funct3; output: XLEN result).
REQ-030 The register array SHALL be NREG-1 flops of XLEN bits; x0 SHALL NOT be stored.

Verification
REQ-031 Reset: hold reset=0 for 2 cycles with RegWriteW=1, RdW=5, ALUResultW=0xDEADBEEF, then release -> A1=5 reads 0x00000000.
REQ-032 Load extend: ReadDataW=0x80F07F01 with LoadTypeW/offset LB/3, LBU/3, LH/2, LHU/2, LB/0 -> ResultW 0xFFFFFF80, 0x00000080, 0xFFFF80F0, 0x000080F0, 0x00000001.
REQ-033 Bypass: RegWriteW=1, RdW=7, ResultSrcW=10, PCPlus4W=0x00000104, A1=A2=7 -> RD1=RD2=0x00000104 in the same cycle, and reg[7]=0x00000104 after the edge.
REQ-034 x0: RegWriteW=1, RdW=0, ALUResultW=0x12345678, A1=0 -> RD1=0 both before and after the edge.
REQ-035 Write disable: write 0xAAAA5555 to x31, then apply RegWriteW=0 with RdW=31 and ALUResultW=0x1 -> x31 stays 0xAAAA5555.
REQ-036 Mid-run reset: fill x1..x31 with their own index values, then pulse reset=0 for 1 cycle during a write to x3 -> all registers read 0 afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 writeback definitions: result-source encoding, load funct3 codes
// and the default datapath width.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_regfile_if.sv
// W-stage bundle: MEM/WB pipeline outputs in, decode read ports and the
// forwarded writeback value out.
interface writeback_regfile_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN_DEFAULT
);
    logic            RegWriteW;
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;
    logic [4:0]      RdW;
    logic [2:0]      LoadTypeW;
    logic [4:0]      A1;
    logic [4:0]      A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] ResultW;

    modport master (
        output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W,
               RdW, LoadTypeW, A1, A2,
        input  RD1, RD2, ResultW
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W,
               RdW, LoadTypeW, A1, A2,
        output RD1, RD2, ResultW
    );
endinterface

// File: rtl/load_extend.sv
// Load lane selection and sign/zero extension of an aligned memory word.
module load_extend
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];

        // unknown funct3 codes fall through to a full-word load
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback result mux plus the architectural register file, with x0 hardwired
// to zero and a same-cycle write-through bypass on both read ports.
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = 32
) (
    input  logic               clk,
    input  logic               reset,
    writeback_regfile_if.slave wb
);

    logic [XLEN-1:0] regs [1:NREG-1];
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            wr_en;
    result_src_t     src;

    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < NREG);
    endfunction

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word   (wb.ReadDataW),
        .offset (wb.ALUResultW[1:0]),
        .funct3 (wb.LoadTypeW),
        .result (load_data)
    );

    assign src = result_src_t'(wb.ResultSrcW);

    always_comb begin
        case (src)
            RES_LOAD: result = load_data;
            RES_PC4:  result = wb.PCPlus4W;
            default:  result = wb.ALUResultW;
        endcase
    end

    assign wr_en = reset && wb.RegWriteW && addr_ok(wb.RdW);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs[i[4:0]] <= '0;
            end
        end else if (wr_en) begin
            regs[wb.RdW] <= result;
        end
    end

    // bypass is gated by wr_en, so it is off during reset and for x0
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (addr_ok(wb.A1)) rd1 = regs[wb.A1];
        if (addr_ok(wb.A2)) rd2 = regs[wb.A2];
        if (wr_en && (wb.RdW == wb.A1)) rd1 = result;
        if (wr_en && (wb.RdW == wb.A2)) rd2 = result;
    end

    assign wb.RD1     = rd1;
    assign wb.RD2     = rd2;
    assign wb.ResultW = result;

endmodule
